// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: fill, wash, drain, N rinse/drain loops, dry.
// One shared down-counter times every step; actuator outputs decode the registered state.
module wash_sequencer #(
  parameter int TW      = 8,
  parameter int FILL_T  = 10,
  parameter int WASH_T  = 20,
  parameter int RINSE_T = 15,
  parameter int DRAIN_T = 8,
  parameter int DRY_T   = 12,
  parameter int N_RINSE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic          start,
  input  logic          pause,
  input  logic          door_closed,
  input  logic          soap_ok,
  input  logic [2:0]    prog_sel,
  output logic          valve_cold,
  output logic          valve_hot,
  output logic          valve_out,
  output logic          motor,
  output logic          door_lock,
  output logic          soap_warning,
  output logic          paused,
  output logic          done,
  output logic          prog_err,
  output logic [3:0]    state,
  output logic [TW-1:0] time_left
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL      = 4'd1,
    S_WAIT_SOAP = 4'd2,
    S_WASH      = 4'd3,
    S_DRAIN_W   = 4'd4,
    S_RINSE     = 4'd5,
    S_DRAIN_R   = 4'd6,
    S_DRY       = 4'd7
  } state_t;

  localparam int QWASH_T = ((WASH_T >> 1) < 1) ? 1 : (WASH_T >> 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    rinse_q, rinse_d;
  logic [2:0]    prog_q, prog_d;
  logic          done_q, done_d, err_q, err_d;
  logic          cold_q, cold_d, hot_q, hot_d, out_q, out_d, motor_q, motor_d;
  logic          lock_q, lock_d, soapw_q, soapw_d;
  logic          freeze_s, last_s, run_s;
  logic [TW-1:0] wash_len_s;

  assign freeze_s   = (state_q != S_IDLE) && (pause || !door_closed);
  assign last_s     = (cnt_q == TW'(1));
  assign wash_len_s = (prog_q == 3'd4) ? TW'(QWASH_T) : TW'(WASH_T);

  // Next-state logic; priority is power loss, then freeze, then soap, then timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rinse_d = rinse_q;
    prog_d  = prog_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (!power) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rinse_d = 3'd0;
    end else if (freeze_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          rinse_d = 3'd0;
          if (start && door_closed && !pause) begin
            case (prog_sel)
              3'd0, 3'd1, 3'd4: begin
                state_d = S_FILL;
                cnt_d   = TW'(FILL_T);
                prog_d  = prog_sel;
              end
              3'd2: begin
                state_d = S_RINSE;
                cnt_d   = TW'(RINSE_T);
                prog_d  = prog_sel;
              end
              3'd3: begin
                state_d = S_DRY;
                cnt_d   = TW'(DRY_T);
                prog_d  = prog_sel;
              end
              default: err_d = 1'b1;
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        // A returning soap_ok cycle counts toward the fill time, so no fill time is lost.
        S_FILL, S_WAIT_SOAP: begin
          if (!soap_ok) begin
            state_d = S_WAIT_SOAP;
          end else if (last_s) begin
            state_d = S_WASH;
            cnt_d   = wash_len_s;
          end else begin
            state_d = S_FILL;
            cnt_d   = cnt_q - TW'(1);
          end
        end
        S_WASH: begin
          if (last_s) begin
            state_d = S_DRAIN_W;
            cnt_d   = TW'(DRAIN_T);
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        S_DRAIN_W: begin
          if (last_s) begin
            state_d = S_RINSE;
            cnt_d   = TW'(RINSE_T);
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        S_RINSE: begin
          if (last_s) begin
            state_d = S_DRAIN_R;
            cnt_d   = TW'(DRAIN_T);
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        S_DRAIN_R: begin
          if (last_s) begin
            rinse_d = rinse_q + 3'd1;
            if (({1'b0, rinse_q} + 4'd1) < 4'(N_RINSE)) begin
              state_d = S_RINSE;
              cnt_d   = TW'(RINSE_T);
            end else begin
              state_d = S_DRY;
              cnt_d   = TW'(DRY_T);
            end
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        S_DRY: begin
          if (last_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Actuator decodes of the upcoming state, registered alongside it.
  always_comb begin
    cold_d  = ((state_d == S_FILL) && (prog_d != 3'd1)) || (state_d == S_RINSE);
    hot_d   = (state_d == S_FILL) && (prog_d == 3'd1);
    out_d   = (state_d == S_DRAIN_W) || (state_d == S_DRAIN_R);
    motor_d = (state_d == S_WASH) || (state_d == S_DRY);
    lock_d  = (state_d != S_IDLE);
    soapw_d = (state_d == S_WAIT_SOAP);
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rinse_q <= 3'd0;
      prog_q  <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cold_q  <= 1'b0;
      hot_q   <= 1'b0;
      out_q   <= 1'b0;
      motor_q <= 1'b0;
      lock_q  <= 1'b0;
      soapw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rinse_q <= rinse_d;
      prog_q  <= prog_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cold_q  <= cold_d;
      hot_q   <= hot_d;
      out_q   <= out_d;
      motor_q <= motor_d;
      lock_q  <= lock_d;
      soapw_q <= soapw_d;
    end
  end

  // Freeze and power loss silence the drivers in the same cycle they occur.
  assign run_s        = power && !freeze_s;
  assign valve_cold   = cold_q && run_s;
  assign valve_hot    = hot_q && run_s;
  assign valve_out    = out_q && run_s;
  assign motor        = motor_q && run_s;
  assign soap_warning = soapw_q && power;
  assign paused       = power && freeze_s;
  assign door_lock    = lock_q;
  assign done         = done_q;
  assign prog_err     = err_q;
  assign state        = state_q;
  assign time_left    = cnt_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: program timing, valve selection, pause, soap wait, errors, power loss.
module tb_wash_sequencer;
  logic       clk = 1'b0;
  logic       rst, power, start, pause, door_closed, soap_ok;
  logic [2:0] prog_sel;
  logic       valve_cold, valve_hot, valve_out, motor, door_lock, soap_warning, paused, done, prog_err;
  logic [3:0] state;
  logic [7:0] time_left;

  int n_checks = 0;
  int n_errors = 0;
  int done_at, wash_cyc, fill_cyc, fill_hot, fill_cold, rinse_cold, any_hot, multi_valve;
  logic [3:0] first_state;
  logic [7:0] first_tl;

  always #5 clk = ~clk;

  wash_sequencer dut (
    .clk(clk), .rst(rst), .power(power), .start(start), .pause(pause),
    .door_closed(door_closed), .soap_ok(soap_ok), .prog_sel(prog_sel),
    .valve_cold(valve_cold), .valve_hot(valve_hot), .valve_out(valve_out), .motor(motor),
    .door_lock(door_lock), .soap_warning(soap_warning), .paused(paused), .done(done),
    .prog_err(prog_err), .state(state), .time_left(time_left)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a program from IDLE and run until done (bounded); optional pause/soap injection.
  task automatic run_prog(input logic [2:0] sel, input int pause_tl, input int soap_tl);
    int n, pcnt, scnt;
    bit pdone, sdone;
    n = 0; pcnt = 0; scnt = 0; pdone = 1'b0; sdone = 1'b0;
    wash_cyc = 0; fill_cyc = 0; fill_hot = 0; fill_cold = 0;
    rinse_cold = 0; any_hot = 0; multi_valve = 0;
    prog_sel = sel;
    start    = 1'b1;
    tick();
    start       = 1'b0;
    prog_sel    = 3'd6;
    first_state = state;
    first_tl    = time_left;
    while (done !== 1'b1 && n < 300) begin
      if (state == 4'd3) wash_cyc++;
      if (state == 4'd1) begin
        fill_cyc++;
        fill_hot  += int'(valve_hot);
        fill_cold += int'(valve_cold);
      end
      if (state == 4'd5) rinse_cold += int'(valve_cold);
      any_hot += int'(valve_hot);
      if ((int'(valve_cold) + int'(valve_hot) + int'(valve_out)) > 1) multi_valve++;
      if (pause_tl > 0 && !pdone && state == 4'd3 && time_left == 8'(pause_tl)) begin
        pause = 1'b1; pcnt = 5; pdone = 1'b1;
      end
      if (soap_tl > 0 && !sdone && state == 4'd1 && time_left == 8'(soap_tl)) begin
        soap_ok = 1'b0; scnt = 3; sdone = 1'b1;
      end
      tick();
      n++;
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 4) begin
          check_eq("pause_tl_hold", time_left, 32'(pause_tl));
          check_eq("pause_motor", motor, 0);
          check_eq("pause_paused", paused, 1);
          check_eq("pause_lock", door_lock, 1);
        end
        if (pcnt == 0) pause = 1'b0;
      end
      if (scnt > 0) begin
        scnt--;
        if (scnt == 2) begin
          check_eq("soap_state", state, 2);
          check_eq("soap_warn", soap_warning, 1);
          check_eq("soap_valve", valve_cold, 0);
        end
        if (scnt == 0) begin
          soap_ok = 1'b1;
          check_eq("soap_resume_tl", time_left, 32'(soap_tl));
        end
      end
    end
    done_at = n;
  endtask

  initial begin
    int n, dcnt;
    rst = 1'b1; power = 1'b1; start = 1'b0; pause = 1'b0;
    door_closed = 1'b1; soap_ok = 1'b1; prog_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_tl", time_left, 0);
    check_eq("rst_outs", {valve_cold, valve_hot, valve_out, motor, door_lock, soap_warning, paused, done, prog_err}, 0);
    rst = 1'b0;
    tick();

    run_prog(3'd0, 0, 0);
    check_eq("p0_first_state", first_state, 1);
    check_eq("p0_first_tl", first_tl, 10);
    check_eq("p0_done_at", done_at, 96);
    check_eq("p0_fill_cold", fill_cold, 10);
    check_eq("p0_no_hot", any_hot, 0);
    check_eq("p0_wash_cyc", wash_cyc, 20);
    check_eq("p0_one_valve", multi_valve, 0);
    check_eq("p0_done_state", state, 0);
    tick();
    check_eq("p0_done_pulse", done, 0);
    check_eq("p0_idle_tl", time_left, 0);

    run_prog(3'd1, 0, 0);
    check_eq("p1_done_at", done_at, 96);
    check_eq("p1_fill_hot", fill_hot, 10);
    check_eq("p1_fill_cold", fill_cold, 0);
    check_eq("p1_rinse_cold", rinse_cold, 30);
    check_eq("p1_one_valve", multi_valve, 0);

    run_prog(3'd4, 0, 0);
    check_eq("p4_done_at", done_at, 86);
    check_eq("p4_wash_cyc", wash_cyc, 10);

    run_prog(3'd3, 0, 0);
    check_eq("p3_first_state", first_state, 7);
    check_eq("p3_first_tl", first_tl, 12);
    check_eq("p3_done_at", done_at, 12);

    run_prog(3'd2, 0, 0);
    check_eq("p2_first_state", first_state, 5);
    check_eq("p2_done_at", done_at, 58);

    run_prog(3'd0, 7, 0);
    check_eq("pause_done_at", done_at, 101);

    run_prog(3'd0, 0, 4);
    check_eq("soap_done_at", done_at, 99);

    tick();
    prog_sel = 3'd6; start = 1'b1;
    tick();
    check_eq("err_pulse", prog_err, 1);
    check_eq("err_state", state, 0);
    check_eq("err_lock", door_lock, 0);
    start = 1'b0;
    tick();
    check_eq("err_pulse_end", prog_err, 0);

    prog_sel = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state !== 4'd5 && n < 200) begin
      tick();
      n++;
    end
    check_eq("pwr_reach_rinse", state, 5);
    power = 1'b0;
    tick();
    check_eq("pwr_state", state, 0);
    check_eq("pwr_outs", {valve_cold, valve_hot, valve_out, motor, door_lock}, 0);
    dcnt = 0;
    repeat (5) begin
      dcnt += int'(done);
      tick();
    end
    check_eq("pwr_no_done", dcnt, 0);
    power = 1'b1;
    tick();
    check_eq("pwr_stay_idle", state, 0);

    prog_sel = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check_eq("rstmid_in_wash", state, 3);
    rst = 1'b1;
    #1;
    check_eq("rstmid_state", state, 0);
    check_eq("rstmid_outs", {motor, door_lock, time_left}, 0);
    rst = 1'b0;
    tick();
    tick();
    check_eq("rstmid_stay_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
